// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch front end and the IF/ID bundle
// that the ID stage consumes.
package fetch_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with +4 increment and a prioritised next-PC select
// (run enable, hazard hold, branch redirect, sequential).
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            pc_write_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] target_aligned;

  // Redirect targets are forced onto a word boundary.
  assign target_aligned = branch_target_i & ~32'h0000_0003;

  always_comb begin
    pc_next = pc_p0;
    if (start_i && pc_write_i) begin
      pc_next = flush_i ? target_aligned : pc_p0 + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pc_next;
    end
  end

  assign pc_o = pc_p0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, IF/ID pipeline register and
// saturating stall/flush debug counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF,
  parameter int              CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [PC_W-1:0]  branch_target_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [PC_W-1:0]  if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  logic [PC_W-1:0]  pc_p0;
  if_id_t           if_id_p1;
  logic [CNT_W-1:0] stall_cnt_p1;
  logic [CNT_W-1:0] flush_cnt_p1;
  logic             flush_accept;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .pc_write_i     (pc_write_i),
    .flush_i        (flush_i),
    .branch_target_i(branch_target_i),
    .pc_o           (pc_p0)
  );

  assign imem_addr_o = pc_p0;

  // IF -> ID boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_id_p1 <= BUBBLE;
    end else if (!start_i) begin
      if_id_p1 <= BUBBLE;
    end else if (!stall_i) begin
      if_id_p1 <= flush_i ? BUBBLE : '{pc: pc_p0, instr: imem_instr_i, valid: 1'b1};
    end
  end

  assign flush_accept = start_i && flush_i && !stall_i && pc_write_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else begin
      if (start_i && stall_i) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush_accept)       flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

  assign if_id_pc_o    = if_id_p1.pc;
  assign if_id_instr_o = if_id_p1.instr;
  assign if_id_valid_o = if_id_p1.valid;
  assign stall_cnt_o   = stall_cnt_p1;
  assign flush_cnt_o   = flush_cnt_p1;

endmodule
